// File: rtl/l2tlb_if.sv
// l2tlb_if: request/response bundle between L1 TLB clients and the L2 TLB host.
//   req[i] : client -> host, {valid, vpn[26:0]}
//   res[i] : host -> client, {valid, ppn[43:0], fault}; valid is a one-cycle pulse
// Modports: host (responder side), client (requester side).
interface l2tlb_if #(
  parameter int N = 2
);
  typedef struct packed {
    logic        valid;
    logic [26:0] vpn;
  } req_t;

  typedef struct packed {
    logic        valid;
    logic [43:0] ppn;
    logic        fault;
  } res_t;

  req_t [N-1:0] req;
  res_t [N-1:0] res;

  modport host   (input req, output res);
  modport client (output req, input res);
endinterface

// File: rtl/l2tlb_host.sv
// l2tlb_host: responder end of l2tlb_if. Small fully-associative Sv39 page
// cache shared by all lanes; misses are serialised through one page-table
// walker handshake and refilled on completion.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tlb             : l2tlb_if.host, req[i] in / res[i] out per lane
//   ptw_req_*       : walk request (valid/ready, vpn)
//   ptw_res_*       : walk result pulse (valid, ppn, fault)
//   flush           : sfence.vma, invalidates every entry
//   busy            : any lane pending or walk in flight
`ifndef NUM_OF_REQ_TO_ITLB
`define NUM_OF_REQ_TO_ITLB 2
`endif
`ifndef NUM_OF_RES_FROM_ITLB
`define NUM_OF_RES_FROM_ITLB 2
`endif

module l2tlb_host #(
  parameter int NUM_OF_REQ  = `NUM_OF_REQ_TO_ITLB,
  parameter int NUM_OF_RES  = `NUM_OF_RES_FROM_ITLB,
  parameter int NUM_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  l2tlb_if.host       tlb,
  output logic        ptw_req_valid,
  input  logic        ptw_req_ready,
  output logic [26:0] ptw_req_vpn,
  input  logic        ptw_res_valid,
  input  logic [43:0] ptw_res_ppn,
  input  logic        ptw_res_fault,
  input  logic        flush,
  output logic        busy
);
  localparam int N     = NUM_OF_REQ;
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  if (NUM_OF_RES != NUM_OF_REQ) begin : g_bad_lanes
    $error("l2tlb_host: NUM_OF_RES must equal NUM_OF_REQ");
  end
  if (NUM_ENTRIES < 2 || NUM_ENTRIES > 64 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("l2tlb_host: NUM_ENTRIES must be a power of two in 2..64");
  end

  // L_LOOKUP is the compare cycle after acceptance (hit responds from here).
  typedef enum logic [1:0] {L_IDLE, L_LOOKUP, L_MISS} lane_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} walk_e;

  lane_e                       lane_st_q [N];
  lane_e                       lane_st_d [N];
  logic [N-1:0][26:0]          lane_vpn_q, lane_vpn_d;
  logic [N-1:0]                res_valid_q, res_valid_d;
  logic [N-1:0][43:0]          res_ppn_q, res_ppn_d;
  logic [N-1:0]                res_fault_q, res_fault_d;

  walk_e                       walk_st_q, walk_st_d;
  logic [26:0]                 walk_vpn_q, walk_vpn_d;
  logic                        flush_seen_q, flush_seen_d;
  logic                        ptw_req_valid_q, ptw_req_valid_d;
  logic                        busy_q, busy_d;

  logic [NUM_ENTRIES-1:0]       ent_valid_q, ent_valid_d;
  logic [NUM_ENTRIES-1:0][26:0] ent_vpn_q, ent_vpn_d;
  logic [NUM_ENTRIES-1:0][43:0] ent_ppn_q, ent_ppn_d;
  logic [IDX_W-1:0]             victim_q, victim_d;

  logic [N-1:0]       lane_hit;
  logic [N-1:0][43:0] lane_hit_ppn;
  logic               walk_done, fill, fill_evict, any_miss;
  logic [IDX_W-1:0]   fill_idx;
  logic [26:0]        miss_vpn;

  assign walk_done = (walk_st_q == W_WAIT) && ptw_res_valid;
  // Flush in the completion cycle or anywhere since W_REQ entry blocks install.
  assign fill      = walk_done && !ptw_res_fault && !flush_seen_q && !flush;

  // Per-lane associative compare against pre-flush/pre-refill contents.
  always_comb begin
    lane_hit     = '0;
    lane_hit_ppn = '0;
    for (int i = 0; i < N; i++)
      for (int e = 0; e < NUM_ENTRIES; e++)
        if (ent_valid_q[e] && ent_vpn_q[e] == lane_vpn_q[i]) begin
          lane_hit[i]     = 1'b1;
          lane_hit_ppn[i] = ent_ppn_q[e];
        end
  end

  // Refill target: existing copy of the VPN, else lowest free, else victim.
  always_comb begin
    fill_idx   = victim_q;
    fill_evict = 1'b1;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--)
      if (!ent_valid_q[e]) begin
        fill_idx   = IDX_W'(e);
        fill_evict = 1'b0;
      end
    for (int e = 0; e < NUM_ENTRIES; e++)
      if (ent_valid_q[e] && ent_vpn_q[e] == walk_vpn_q) begin
        fill_idx   = IDX_W'(e);
        fill_evict = 1'b0;
      end
  end

  always_comb begin
    lane_st_d    = lane_st_q;
    lane_vpn_d   = lane_vpn_q;
    res_valid_d  = '0;
    res_ppn_d    = res_ppn_q;
    res_fault_d  = res_fault_q;
    walk_st_d    = walk_st_q;
    walk_vpn_d   = walk_vpn_q;
    flush_seen_d = flush_seen_q;
    ent_valid_d  = ent_valid_q;
    ent_vpn_d    = ent_vpn_q;
    ent_ppn_d    = ent_ppn_q;
    victim_d     = victim_q;
    any_miss     = 1'b0;
    miss_vpn     = '0;

    for (int i = 0; i < N; i++) begin
      case (lane_st_q[i])
        L_IDLE:
          if (tlb.req[i].valid) begin
            lane_st_d[i]  = L_LOOKUP;
            lane_vpn_d[i] = tlb.req[i].vpn;
          end
        L_LOOKUP:
          if (lane_hit[i]) begin
            res_valid_d[i] = 1'b1;
            res_ppn_d[i]   = lane_hit_ppn[i];
            res_fault_d[i] = 1'b0;
            lane_st_d[i]   = L_IDLE;
          end else begin
            lane_st_d[i] = L_MISS;
          end
        L_MISS:
          // Every lane waiting on the walked VPN shares the one result.
          if (walk_done && lane_vpn_q[i] == walk_vpn_q) begin
            res_valid_d[i] = 1'b1;
            res_ppn_d[i]   = ptw_res_ppn;
            res_fault_d[i] = ptw_res_fault;
            lane_st_d[i]   = L_IDLE;
          end
        default: lane_st_d[i] = L_IDLE;
      endcase
    end

    // Lowest-index MISS lane wins the walker.
    for (int i = N - 1; i >= 0; i--)
      if (lane_st_q[i] == L_MISS) begin
        any_miss = 1'b1;
        miss_vpn = lane_vpn_q[i];
      end

    case (walk_st_q)
      W_IDLE:
        if (any_miss) begin
          walk_st_d    = W_REQ;
          walk_vpn_d   = miss_vpn;
          flush_seen_d = 1'b0;
        end
      W_REQ: begin
        flush_seen_d = flush_seen_q | flush;
        if (ptw_req_ready) walk_st_d = W_WAIT;
      end
      W_WAIT: begin
        flush_seen_d = flush_seen_q | flush;
        if (ptw_res_valid) walk_st_d = W_IDLE;
      end
      default: walk_st_d = W_IDLE;
    endcase

    if (flush) begin
      ent_valid_d = '0;
    end else if (fill) begin
      ent_valid_d[fill_idx] = 1'b1;
      ent_vpn_d[fill_idx]   = walk_vpn_q;
      ent_ppn_d[fill_idx]   = ptw_res_ppn;
      if (fill_evict) victim_d = victim_q + 1'b1;
    end

    ptw_req_valid_d = (walk_st_d == W_REQ);
    busy_d          = (walk_st_d != W_IDLE);
    for (int i = 0; i < N; i++)
      if (lane_st_d[i] != L_IDLE) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) lane_st_q[i] <= L_IDLE;
      lane_vpn_q      <= '0;
      res_valid_q     <= '0;
      res_ppn_q       <= '0;
      res_fault_q     <= '0;
      walk_st_q       <= W_IDLE;
      walk_vpn_q      <= '0;
      flush_seen_q    <= 1'b0;
      ptw_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      ent_valid_q     <= '0;
      ent_vpn_q       <= '0;
      ent_ppn_q       <= '0;
      victim_q        <= '0;
    end else begin
      lane_st_q       <= lane_st_d;
      lane_vpn_q      <= lane_vpn_d;
      res_valid_q     <= res_valid_d;
      res_ppn_q       <= res_ppn_d;
      res_fault_q     <= res_fault_d;
      walk_st_q       <= walk_st_d;
      walk_vpn_q      <= walk_vpn_d;
      flush_seen_q    <= flush_seen_d;
      ptw_req_valid_q <= ptw_req_valid_d;
      busy_q          <= busy_d;
      ent_valid_q     <= ent_valid_d;
      ent_vpn_q       <= ent_vpn_d;
      ent_ppn_q       <= ent_ppn_d;
      victim_q        <= victim_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_res
    assign tlb.res[g].valid = res_valid_q[g];
    assign tlb.res[g].ppn   = res_ppn_q[g];
    assign tlb.res[g].fault = res_fault_q[g];
  end

  assign ptw_req_valid = ptw_req_valid_q;
  assign ptw_req_vpn   = walk_vpn_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_l2tlb_host.sv
// Bench for l2tlb_host: directed table, hand sequences for multi-cycle
// corners, and randomized single-request traffic checked against a
// behavioural cache model. A tick-driven walker model answers walks.
module tb_l2tlb_host;
  localparam int NL = 2;
  localparam int NE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ptw_req_valid, ptw_req_ready;
  logic [26:0] ptw_req_vpn;
  logic        ptw_res_valid, ptw_res_fault;
  logic [43:0] ptw_res_ppn;
  logic        flush, busy;

  int n_chk = 0;
  int n_err = 0;
  int walk_cnt = 0;
  bit auto_walk = 1'b0;
  int w_phase = 0;
  int w_dly = 0;
  logic [26:0] w_vpn;

  bit          m_valid [NE];
  logic [26:0] m_vpn   [NE];
  int          m_victim;

  l2tlb_if #(.N(NL)) tlb_bus ();

  l2tlb_host #(.NUM_OF_REQ(NL), .NUM_OF_RES(NL), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst), .tlb(tlb_bus),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_res_valid(ptw_res_valid), .ptw_res_ppn(ptw_res_ppn), .ptw_res_fault(ptw_res_fault),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] ppn_of(input logic [26:0] v);
    return {17'h0, v} * 44'd3 + 44'h100;
  endfunction

  function automatic bit is_fault(input logic [26:0] v);
    return (v == 27'h55) || ((v >= 27'd24) && (v[2:0] == 3'd5));
  endfunction

  // Cache model: hit -> no walk; miss -> walk, install unless fault,
  // lowest free slot first, else round-robin victim.
  function automatic bit model_access(input logic [26:0] v);
    for (int e = 0; e < NE; e++) if (m_valid[e] && m_vpn[e] == v) return 1'b0;
    if (is_fault(v)) return 1'b1;
    for (int e = 0; e < NE; e++)
      if (!m_valid[e]) begin m_valid[e] = 1'b1; m_vpn[e] = v; return 1'b1; end
    m_vpn[m_victim] = v;
    m_victim = (m_victim + 1) % NE;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic walker_step();
    case (w_phase)
      0: if (ptw_req_valid) begin w_dly = $urandom_range(0, 2); w_phase = 1; end
      1: if (w_dly == 0) begin
           ptw_req_ready = 1'b1; w_vpn = ptw_req_vpn; walk_cnt++; w_phase = 2;
         end else w_dly--;
      2: begin ptw_req_ready = 1'b0; w_dly = $urandom_range(0, 3); w_phase = 3; end
      3: if (w_dly == 0) begin
           ptw_res_valid = 1'b1; ptw_res_ppn = ppn_of(w_vpn); ptw_res_fault = is_fault(w_vpn); w_phase = 4;
         end else w_dly--;
      default: begin ptw_res_valid = 1'b0; w_phase = 0; end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    if (auto_walk) walker_step();
  endtask

  task automatic reset_all();
    rst = 1'b1;
    tlb_bus.req = '0;
    repeat (2) tick();
    rst = 1'b0;
    w_phase = 0;
    ptw_req_ready = 1'b0; ptw_res_valid = 1'b0; ptw_res_fault = 1'b0; flush = 1'b0;
    for (int e = 0; e < NE; e++) m_valid[e] = 1'b0;
    m_victim = 0;
  endtask

  task automatic drive_req(input logic [NL-1:0] mask, input logic [26:0] v);
    tick();
    for (int i = 0; i < NL; i++)
      if (mask[i]) begin tlb_bus.req[i].valid = 1'b1; tlb_bus.req[i].vpn = v; end
    tick();
    for (int i = 0; i < NL; i++) tlb_bus.req[i].valid = 1'b0;
  endtask

  task automatic wait_ptw(output int lat);
    lat = -1;
    for (int k = 1; k < 30; k++) begin
      tick();
      if (ptw_req_valid) begin lat = k; break; end
    end
  endtask

  // lat counts negedges from the drive edge; a hit answers at 2.
  task automatic run_req(input int lane, input logic [26:0] v, output bit walked,
                         output logic [43:0] ppn, output logic fault, output int lat);
    int w0;
    logic [NL-1:0] m;
    w0 = walk_cnt; m = '0; m[lane] = 1'b1; ppn = '0; fault = 1'b0; lat = -1;
    drive_req(m, v);
    for (int k = 2; k < 80; k++) begin
      tick();
      if (tlb_bus.res[lane].valid) begin
        lat = k; ppn = tlb_bus.res[lane].ppn; fault = tlb_bus.res[lane].fault; break;
      end
    end
    walked = (walk_cnt != w0);
  endtask

  task automatic check_model(input int lane, input logic [26:0] v, input string name);
    bit walked, ew;
    logic [43:0] p;
    logic f;
    int lat;
    ew = model_access(v);
    run_req(lane, v, walked, p, f, lat);
    chk({name, "_resp"}, lat > 0, 1);
    chk({name, "_walk"}, walked, ew);
    chk({name, "_ppn"}, p, ppn_of(v));
    chk({name, "_fault"}, f, is_fault(v));
    if (!ew) chk({name, "_hitlat"}, lat, 2);
  endtask

  typedef struct {
    int          lane;
    logic [26:0] vpn;
    bit          walk;
    bit          fault;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit          wk;
    logic [43:0] p;
    logic        f;
    int          lat, cnt;

    tbl[0] = '{0, 27'h123, 1'b1, 1'b0};
    tbl[1] = '{1, 27'h123, 1'b0, 1'b0};
    tbl[2] = '{0, 27'h055, 1'b1, 1'b1};
    tbl[3] = '{1, 27'h055, 1'b1, 1'b1};
    tbl[4] = '{1, 27'h200, 1'b1, 1'b0};
    tbl[5] = '{0, 27'h200, 1'b0, 1'b0};
    tbl[6] = '{0, 27'h02D, 1'b1, 1'b1};
    tbl[7] = '{1, 27'h123, 1'b0, 1'b0};

    flush = 1'b0; ptw_req_ready = 1'b0; ptw_res_valid = 1'b0;
    ptw_res_ppn = '0; ptw_res_fault = 1'b0; w_vpn = '0;
    reset_all();
    chk("rst_res", tlb_bus.res, 0);
    chk("rst_ptw_valid", ptw_req_valid, 0);
    chk("rst_ptw_vpn", ptw_req_vpn, 0);
    chk("rst_busy", busy, 0);

    // Cold miss, manual walker.
    drive_req(2'b01, 27'h123);
    wait_ptw(lat);
    chk("cold_req_lat", lat, 2);
    chk("cold_req_vpn", ptw_req_vpn, 27'h123);
    ptw_req_ready = 1'b1; tick(); ptw_req_ready = 1'b0;
    chk("cold_req_drop", ptw_req_valid, 0);
    tick(); tick();
    ptw_res_valid = 1'b1; ptw_res_ppn = 44'h00000ABCD; ptw_res_fault = 1'b0;
    tick(); ptw_res_valid = 1'b0;
    chk("cold_res_valid", tlb_bus.res[0].valid, 1);
    chk("cold_res_ppn", tlb_bus.res[0].ppn, 44'h00000ABCD);
    chk("cold_res_fault", tlb_bus.res[0].fault, 0);
    tick();
    chk("cold_res_pulse", tlb_bus.res[0].valid, 0);
    run_req(0, 27'h123, wk, p, f, lat);
    chk("rehit_lat", lat, 2);
    chk("rehit_ppn", p, 44'h00000ABCD);

    // Two lanes, same VPN, one walk.
    drive_req(2'b11, 27'h7);
    wait_ptw(lat);
    chk("dual_req_vpn", ptw_req_vpn, 27'h7);
    ptw_req_ready = 1'b1; tick(); ptw_req_ready = 1'b0; tick();
    ptw_res_valid = 1'b1; ptw_res_ppn = 44'h777; ptw_res_fault = 1'b0;
    tick(); ptw_res_valid = 1'b0;
    chk("dual_res_valid", {tlb_bus.res[1].valid, tlb_bus.res[0].valid}, 2'b11);
    chk("dual_res_ppn0", tlb_bus.res[0].ppn, 44'h777);
    chk("dual_res_ppn1", tlb_bus.res[1].ppn, 44'h777);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin tick(); if (ptw_req_valid) cnt++; end
    chk("dual_one_walk", cnt, 0);

    // Directed table with auto walker.
    reset_all();
    auto_walk = 1'b1;
    for (int t = 0; t < 8; t++) begin
      void'(model_access(tbl[t].vpn));
      run_req(tbl[t].lane, tbl[t].vpn, wk, p, f, lat);
      chk($sformatf("tbl%0d_resp", t), lat > 0, 1);
      chk($sformatf("tbl%0d_walk", t), wk, tbl[t].walk);
      chk($sformatf("tbl%0d_ppn", t), p, ppn_of(tbl[t].vpn));
      chk($sformatf("tbl%0d_fault", t), f, tbl[t].fault);
      if (!tbl[t].walk) chk($sformatf("tbl%0d_hitlat", t), lat, 2);
    end

    // Replacement: 16 fills, 17th evicts entry 0, pointer moves to 1.
    reset_all();
    for (int v = 0; v <= 16; v++) check_model(0, 27'(v), $sformatf("fill%0d", v));
    check_model(1, 27'd1, "repl_hit1");
    check_model(0, 27'd0, "repl_miss0");
    check_model(1, 27'd16, "repl_hit16");
    check_model(1, 27'd1, "repl_miss1");

    // Flush while the walk for 0x9 waits.
    reset_all();
    check_model(0, 27'h1, "pre_fl1");
    check_model(1, 27'h2, "pre_fl2");
    auto_walk = 1'b0;
    drive_req(2'b01, 27'h9);
    wait_ptw(lat);
    chk("fl_req_vpn", ptw_req_vpn, 27'h9);
    ptw_req_ready = 1'b1; tick(); ptw_req_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0; tick();
    ptw_res_valid = 1'b1; ptw_res_ppn = ppn_of(27'h9); ptw_res_fault = 1'b0;
    tick(); ptw_res_valid = 1'b0;
    chk("fl_res_valid", tlb_bus.res[0].valid, 1);
    chk("fl_res_ppn", tlb_bus.res[0].ppn, ppn_of(27'h9));
    for (int e = 0; e < NE; e++) m_valid[e] = 1'b0;
    auto_walk = 1'b1;
    check_model(0, 27'h9, "post_fl9");
    check_model(1, 27'h1, "post_fl1");

    // Randomized traffic vs model, occasional idle flush.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        tick(); flush = 1'b1; tick(); flush = 1'b0;
        for (int e = 0; e < NE; e++) m_valid[e] = 1'b0;
      end
      check_model(int'($urandom_range(0, 1)), 27'($urandom_range(0, 47)), $sformatf("rnd%0d", it));
    end

    // Backpressure, then reset mid-walk and a stray result.
    auto_walk = 1'b0;
    reset_all();
    drive_req(2'b01, 27'h44);
    wait_ptw(lat);
    chk("bp_req_seen", lat > 0, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), ptw_req_valid, 1);
      chk($sformatf("bp_vpn%0d", k), ptw_req_vpn, 27'h44);
      chk($sformatf("bp_busy%0d", k), busy, 1);
      tick();
    end
    ptw_req_ready = 1'b1; tick(); ptw_req_ready = 1'b0;
    chk("bp_wait_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_valid", ptw_req_valid, 0);
    chk("mrst_busy", busy, 0);
    ptw_res_valid = 1'b1; ptw_res_ppn = 44'hDEAD; ptw_res_fault = 1'b0;
    tick(); ptw_res_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (tlb_bus.res[0].valid || tlb_bus.res[1].valid || ptw_req_valid) cnt++;
      tick();
    end
    chk("mrst_stray", cnt, 0);
    chk("mrst_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
